// File: rtl/sort_topk_merge.sv
// sort_topk_merge: rebases per-block local indices to global indices and merges
// LANES sorted lists per beat into a running global top-K. The final list is
// presented with a valid/ready handshake after the beat flagged last.
module sort_topk_merge #(
    parameter int DATA_W    = 8,
    parameter int IDX_W     = 16,
    parameter int K         = 5,
    parameter int LANES     = 2,
    parameter int BLK_SHIFT = 5
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic                                  sorter_clr,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic [IDX_W-1:0]                      in_block,
    input  logic [LANES*K*(IDX_W+DATA_W)-1:0]     in_data,
    input  logic [LANES*K-1:0]                    in_vld,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [K*(IDX_W+DATA_W)-1:0]           out_data,
    output logic [$clog2(K+1)-1:0]                out_count,
    output logic                                  idx_ovf
);

    localparam int EW  = IDX_W + DATA_W;
    localparam int NIN = LANES * K;
    localparam int NC  = NIN + K;
    localparam int CW  = $clog2(K + 1);
    localparam int RW  = $clog2(NC + 1);
    localparam int SW  = IDX_W + BLK_SHIFT + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]             state_q, state_d;
    logic                   last_seen_q, last_seen_d;

    // Input capture stage
    logic                   vld_p0_q;
    logic                   last_p0_q;
    logic [IDX_W-1:0]       blk_p0_q;
    logic [NIN*EW-1:0]      data_p0_q;
    logic [NIN-1:0]         ev_p0_q;

    // Rebase stage
    logic                   vld_p1_q;
    logic                   last_p1_q;
    logic [NIN*EW-1:0]      data_p1_q;
    logic [NIN-1:0]         ev_p1_q;

    // Running top-K list
    logic [K*EW-1:0]        run_data_q;
    logic [K-1:0]           run_vld_q;
    logic                   ovf_q;

    logic                   accept;
    logic                   hs;
    logic                   flush;
    logic [NIN*EW-1:0]      reb_data;
    logic                   reb_ovf;
    logic [EW-1:0]          cand_e [NC];
    logic                   cand_v [NC];
    logic [RW-1:0]          rank   [NC];
    logic [K*EW-1:0]        merged_data;
    logic [K-1:0]           merged_vld;

    // Full-precision sum of a local index and the block offset
    function automatic logic [SW-1:0] rebase_sum(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] blk);
        rebase_sum = SW'(idx) + (SW'(blk) << BLK_SHIFT);
    endfunction

    // Strict rank order: valid first, then larger data, then smaller index
    function automatic logic beats(input logic [EW-1:0] ea, input logic va,
                                   input logic [EW-1:0] eb, input logic vb);
        if (va != vb)
            beats = va;
        else if (ea[DATA_W-1:0] != eb[DATA_W-1:0])
            beats = ea[DATA_W-1:0] > eb[DATA_W-1:0];
        else
            beats = ea[EW-1:DATA_W] < eb[EW-1:DATA_W];
    endfunction

    assign accept    = in_valid && in_ready;
    assign hs        = (state_q == DONE) && out_ready;
    assign flush     = sorter_clr || hs;
    assign in_ready  = (state_q != DONE) && !last_seen_q;
    assign out_valid = (state_q == DONE);
    assign out_data  = run_data_q;
    assign idx_ovf   = ovf_q;

    // Next-state logic for the sort control FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (vld_p1_q && last_p1_q) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (sorter_clr) state_d = IDLE;
    end

    // Track that the last beat has been taken so input stalls until the result drains
    always_comb begin
        last_seen_d = last_seen_q;
        if (flush)
            last_seen_d = 1'b0;
        else if (accept && in_last)
            last_seen_d = 1'b1;
    end

    // Control registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_seen_q <= last_seen_d;
        end
    end

    // ---- stage p0: capture accepted beat ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
            blk_p0_q  <= '0;
            data_p0_q <= '0;
            ev_p0_q   <= '0;
        end else if (flush) begin
            vld_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
            blk_p0_q  <= '0;
            data_p0_q <= '0;
            ev_p0_q   <= '0;
        end else begin
            vld_p0_q <= accept;
            if (accept) begin
                last_p0_q <= in_last;
                blk_p0_q  <= in_block;
                data_p0_q <= in_data;
                ev_p0_q   <= in_vld;
            end
        end
    end

    // Rebase every entry of the captured beat and flag index overflow
    always_comb begin
        reb_data = data_p0_q;
        reb_ovf  = 1'b0;
        for (int e = 0; e < NIN; e++) begin
            logic [SW-1:0] s;
            s = rebase_sum(data_p0_q[e*EW+DATA_W +: IDX_W], blk_p0_q);
            reb_data[e*EW+DATA_W +: IDX_W] = s[IDX_W-1:0];
            if (ev_p0_q[e] && (s[SW-1:IDX_W] != '0))
                reb_ovf = 1'b1;
        end
    end

    // ---- stage p1: rebased beat ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            data_p1_q <= '0;
            ev_p1_q   <= '0;
        end else if (flush) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            data_p1_q <= '0;
            ev_p1_q   <= '0;
        end else begin
            vld_p1_q <= vld_p0_q;
            if (vld_p0_q) begin
                last_p1_q <= last_p0_q;
                data_p1_q <= reb_data;
                ev_p1_q   <= ev_p0_q;
            end
        end
    end

    // Sticky overflow flag for the current sort
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            ovf_q <= 1'b0;
        else if (flush)
            ovf_q <= 1'b0;
        else if (vld_p0_q && reb_ovf)
            ovf_q <= 1'b1;
    end

    // Gather running entries and the rebased beat as merge candidates
    always_comb begin
        for (int i = 0; i < K; i++) begin
            cand_e[i] = run_data_q[i*EW +: EW];
            cand_v[i] = run_vld_q[i];
        end
        for (int i = 0; i < NIN; i++) begin
            cand_e[K+i] = data_p1_q[i*EW +: EW];
            cand_v[K+i] = ev_p1_q[i];
        end
    end

    // Rank each candidate by counting how many others beat it; exact ties
    // fall back to candidate position so ranks form a permutation
    always_comb begin
        for (int i = 0; i < NC; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NC; j++) begin
                if (j != i) begin
                    if (beats(cand_e[j], cand_v[j], cand_e[i], cand_v[i]) ||
                        (!beats(cand_e[i], cand_v[i], cand_e[j], cand_v[j]) && (j < i)))
                        rank[i] = rank[i] + RW'(1);
                end
            end
        end
    end

    // Route the K best-ranked candidates into list order, zeroing invalid slots
    always_comb begin
        merged_data = '0;
        merged_vld  = '0;
        for (int r = 0; r < K; r++) begin
            for (int i = 0; i < NC; i++) begin
                if ((rank[i] == RW'(r)) && cand_v[i]) begin
                    merged_data[r*EW +: EW] = merged_data[r*EW +: EW] | cand_e[i];
                    merged_vld[r]           = 1'b1;
                end
            end
        end
    end

    // ---- stage p2: running list update ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            run_data_q <= '0;
            run_vld_q  <= '0;
        end else if (flush) begin
            run_data_q <= '0;
            run_vld_q  <= '0;
        end else if (vld_p1_q) begin
            run_data_q <= merged_data;
            run_vld_q  <= merged_vld;
        end
    end

    // Count valid result entries
    always_comb begin
        out_count = '0;
        for (int i = 0; i < K; i++)
            out_count = out_count + CW'(run_vld_q[i]);
    end

endmodule

// File: tb/tb_sort_topk_merge.sv
// Testbench for sort_topk_merge: directed scenarios followed by randomized sorts
// checked against a top-K-of-union reference model.
module tb_sort_topk_merge;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 16;
    localparam int K      = 5;
    localparam int LANES  = 2;
    localparam int BSH    = 5;
    localparam int EW     = IDX_W + DATA_W;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst_n;
    logic                     sorter_clr;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [IDX_W-1:0]         in_block;
    logic [LANES*K*EW-1:0]    in_data;
    logic [LANES*K-1:0]       in_vld;
    logic                     out_valid;
    logic                     out_ready;
    logic [K*EW-1:0]          out_data;
    logic [$clog2(K+1)-1:0]   out_count;
    logic                     idx_ovf;

    sort_topk_merge #(.DATA_W(DATA_W), .IDX_W(IDX_W), .K(K), .LANES(LANES), .BLK_SHIFT(BSH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sorter_clr(sorter_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_block(in_block), .in_data(in_data), .in_vld(in_vld),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .idx_ovf(idx_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    int b_idx [LANES][K];
    int b_dat [LANES][K];
    bit b_v   [LANES][K];

    int m_idx [$];
    int m_dat [$];
    bit m_ovf;

    logic [K*EW-1:0] exp_data;
    int              exp_cnt;
    logic [K*EW-1:0] held;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_beat();
        for (int l = 0; l < LANES; l++)
            for (int e = 0; e < K; e++) begin
                b_idx[l][e] = 0;
                b_dat[l][e] = 0;
                b_v[l][e]   = 1'b0;
            end
    endtask

    task automatic base_beat();
        for (int e = 0; e < K; e++) begin
            b_dat[0][e] = 90 - 10 * e;  b_idx[0][e] = e;      b_v[0][e] = 1'b1;
            b_dat[1][e] = 85 - 10 * e;  b_idx[1][e] = 16 + e; b_v[1][e] = 1'b1;
        end
    endtask

    task automatic tie_beat();
        clear_beat();
        b_idx[0][0] = 7; b_dat[0][0] = 50; b_v[0][0] = 1'b1;
        b_idx[1][0] = 3; b_dat[1][0] = 50; b_v[1][0] = 1'b1;
    endtask

    task automatic drive_beat(input int blk, input bit last);
        for (int l = 0; l < LANES; l++)
            for (int e = 0; e < K; e++) begin
                in_data[(l*K+e)*EW +: EW] = {16'(b_idx[l][e]), 8'(b_dat[l][e])};
                in_vld[l*K+e]             = b_v[l][e];
            end
        in_block = 16'(blk);
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic model_reset();
        m_idx.delete();
        m_dat.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_add(input int blk);
        longint s;
        for (int l = 0; l < LANES; l++)
            for (int e = 0; e < K; e++)
                if (b_v[l][e]) begin
                    s = longint'(b_idx[l][e]) + longint'(blk) * (longint'(1) << BSH);
                    if (s >= 65536) m_ovf = 1'b1;
                    m_idx.push_back(int'(s % 65536));
                    m_dat.push_back(b_dat[l][e]);
                end
    endtask

    // Top-K of every valid entry seen in the sort, by data desc then index asc
    task automatic model_expect();
        bit used [$];
        int best;
        exp_data = '0;
        exp_cnt  = 0;
        foreach (m_idx[i]) used.push_back(1'b0);
        for (int r = 0; r < K; r++) begin
            best = -1;
            foreach (m_idx[i])
                if (!used[i]) begin
                    if (best < 0 || m_dat[i] > m_dat[best] ||
                        (m_dat[i] == m_dat[best] && m_idx[i] < m_idx[best]))
                        best = i;
                end
            if (best >= 0) begin
                used[best] = 1'b1;
                exp_data[r*EW +: EW] = {16'(m_idx[best]), 8'(m_dat[best])};
                exp_cnt++;
            end
        end
    endtask

    task automatic send(input int blk, input bit last);
        drive_beat(blk, last);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_add(blk);
    endtask

    // Called right after the last beat's accepting edge
    task automatic check_result(input string tag);
        chk({tag, "_rdy_drop"}, in_ready, 1'b0);
        chk({tag, "_vld_t1"}, out_valid, 1'b0);
        step();
        chk({tag, "_vld_t2m"}, out_valid, 1'b0);
        step();
        chk({tag, "_vld_t2"}, out_valid, 1'b1);
        model_expect();
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_count"}, out_count, exp_cnt);
        chk({tag, "_ovf"}, idx_ovf, m_ovf);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_hs_vld"}, out_valid, 1'b0);
        chk({tag, "_hs_rdy"}, in_ready, 1'b1);
        chk({tag, "_hs_cnt"}, out_count, 0);
        chk({tag, "_hs_ovf"}, idx_ovf, 1'b0);
        model_reset();
    endtask

    initial begin
        int nb, blk, t;
        sys_rst_n  = 1'b0;
        sorter_clr = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_block   = '0;
        in_data    = '0;
        in_vld     = '0;
        out_ready  = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_idx_ovf", idx_ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        sys_rst_n = 1'b1;
        step();

        // Single last beat, block 0
        clear_beat(); base_beat();
        send(0, 1'b1);
        check_result("single");
        chk("single_const", out_data,
            {16'd2, 8'd70, 16'd17, 8'd75, 16'd1, 8'd80, 16'd16, 8'd85, 16'd0, 8'd90});
        handshake("single");

        // Two beats, block 0 then block 3 last
        clear_beat(); base_beat();
        send(0, 1'b0);
        clear_beat();
        b_idx[0][0] = 4; b_dat[0][0] = 200; b_v[0][0] = 1'b1;
        send(3, 1'b1);
        check_result("two");
        chk("two_entry0", out_data[EW-1:0], {16'd100, 8'd200});
        handshake("two");

        // Tie on data resolved by smaller global index
        tie_beat();
        send(0, 1'b1);
        check_result("tie");
        chk("tie_const", out_data, {72'd0, 16'd7, 8'd50, 16'd3, 8'd50});
        handshake("tie");

        // Backpressure: output held, input ignored
        clear_beat(); base_beat();
        send(0, 1'b1);
        check_result("bp");
        held = out_data;
        tie_beat();
        for (int c = 0; c < 5; c++) begin
            drive_beat(c, 1'b1);
            in_valid = c[0];
            step();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_data", out_data, held);
        end
        in_valid = 1'b0;
        handshake("bp");

        // Index overflow
        clear_beat();
        b_idx[0][0] = 1; b_dat[0][0] = 9; b_v[0][0] = 1'b1;
        send(16'h0800, 1'b1);
        check_result("ovf");
        chk("ovf_flag", idx_ovf, 1'b1);
        chk("ovf_entry0", out_data[EW-1:0], {16'd1, 8'd9});
        handshake("ovf");
        clear_beat(); base_beat();
        send(0, 1'b1);
        check_result("post_ovf");
        handshake("post_ovf");

        // sorter_clr mid-sort, with a beat offered on the clear edge
        clear_beat(); base_beat();
        send(0, 1'b0);
        tie_beat();
        drive_beat(0, 1'b1);
        sorter_clr = 1'b1;
        step();
        sorter_clr = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        model_reset();
        chk("clr_in_ready", in_ready, 1'b1);
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_count", out_count, 0);
        chk("clr_data", out_data, 0);
        step(); step(); step();
        chk("clr_drop_count", out_count, 0);
        chk("clr_drop_valid", out_valid, 1'b0);
        tie_beat();
        send(0, 1'b1);
        check_result("after_clr");
        handshake("after_clr");

        // Asynchronous reset while DONE
        clear_beat(); base_beat();
        send(0, 1'b1);
        check_result("arst");
        sys_rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_count", out_count, 0);
        #2;
        sys_rst_n = 1'b1;
        model_reset();
        step();

        // Randomized sorts
        for (int s = 0; s < 16; s++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int e = 0; e < K; e++) begin
                        b_dat[l][e] = $urandom_range(0, 255);
                        b_idx[l][e] = $urandom_range(0, 31);
                        b_v[l][e]   = ($urandom_range(0, 3) != 0);
                    end
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K - 1 - i; j++)
                            if (b_dat[l][j] < b_dat[l][j+1]) begin
                                t = b_dat[l][j]; b_dat[l][j] = b_dat[l][j+1]; b_dat[l][j+1] = t;
                            end
                end
                blk = ($urandom_range(0, 3) == 0) ? $urandom_range(16'h07F0, 16'hFFFF)
                                                  : $urandom_range(0, 64);
                send(blk, b == nb - 1);
            end
            check_result("rand");
            held = out_data;
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                step();
                chk("rand_hold", out_data, held);
            end
            handshake("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sort_topk_merge.md
# sort_topk_merge

Parametrised top-K rebase-and-merge stage for the NPU sort pipeline. Each accepted beat carries LANES locally sorted lists of K {index, data} entries for one input block. The stage rebases each local index to a global index using the block number, then merges all lanes into a running global top-K held across blocks. On the beat flagged last, it presents the final sorted top-K with a valid/ready handshake. It sits after the per-block sorters and feeds the result writeback.

## Interface
- DATA_W, 8: entry data width, unsigned magnitude
- IDX_W, 16: index width (local and global)
- K, 5: entries per lane and size of the result list
- LANES, 2: number of input lanes
- BLK_SHIFT, 5: log2 of block size; offset = in_block << BLK_SHIFT
- sys_clk  in  1  clock, rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- sorter_clr  in  1  synchronous clear of all state, priority over everything except reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage accepts a beat
- in_last  in  1  final block of the current sort
- in_block  in  IDX_W  0-based block number
- in_data  in  LANES*K*(IDX_W+DATA_W)  entry e of lane l at [(l*K+e)*EW +: EW], EW=IDX_W+DATA_W, packed {idx, data}; each lane sorted descending, entry 0 largest
- in_vld  in  LANES*K  per-entry valid, same ordering
- out_valid  out  1  result available
- out_ready  in  1  downstream takes result
- out_data  out  K*EW  global top-K, entry 0 largest, same packing
- out_count  out  $clog2(K+1)  number of valid result entries
- idx_ovf  out  1  sticky: some rebased index exceeded 2^IDX_W-1 during this sort

## Operation
- State machine: IDLE, ACCUM, DONE.
  - IDLE to ACCUM on the first accepted beat.
  - ACCUM to DONE when the last beat has merged.
  - DONE to IDLE on out_valid&&out_ready.
- A beat is accepted when in_valid&&in_ready.
- in_ready = 1 in IDLE and ACCUM. It drops the cycle after a last beat is accepted and stays 0 until the result handshake completes.
- S1 (rebase register): each global index = (local_idx + (in_block<<BLK_SHIFT)) mod 2^IDX_W. The data field and valid bits pass unchanged.
  - If the full-precision sum is ≥ 2^IDX_W for a valid entry, set idx_ovf (sticky).
- S2 (merge): the candidates are the LANES*K rebased entries plus the K running entries, each with its valid bit.
  - Rank order: valid beats invalid; then larger data; then smaller global index.
  - The K best are written back to the running list in order, with valid bits.
- Invalid entries in the running list and in out_data read as all-zero.
- On DONE entry, out_data holds the running list and out_count = number of valid entries (0..K).
- On leaving DONE, the running list, valid bits, idx_ovf and pipeline are cleared for the next sort.
- A beat with all in_vld = 0 is legal. It still advances the pipeline and honours in_last.
- sorter_clr: return to IDLE, clear the running list, S1, out_valid and idx_ovf. in_ready is 1 the next cycle.
- Reset values: out_valid=0, out_data=0, out_count=0, idx_ovf=0, in_ready=1 (IDLE), all internal registers 0.

## Timing
- Beat accepted at edge t: rebased at t+1, merged into the running list at t+2.
- Last beat accepted at t: out_valid=1 from t+2 until the handshake edge.
- Full throughput: one beat per cycle in ACCUM.
- out_data, out_count and idx_ovf are stable while out_valid=1 and out_ready=0.
- out_valid falls the cycle after the handshake. in_ready rises in that same cycle.
- sorter_clr and a beat on the same edge: the clear wins and the beat is dropped.
- Async reset mid-sort: all outputs take their reset values immediately. The sort is abandoned.

## Test plan
- Single last beat, block 0:
  - Stimulus: lane0 data 90,80,70,60,50 idx 0..4; lane1 data 85,75,65,55,45 idx 16..20; all valid.
  - Response: out_data data 90,85,80,75,70 idx 0,16,1,17,2; out_count=5; out_valid at t+2.
- Two beats, block 0 (same as above) then last block 3:
  - Stimulus: lane0 entry 0 data 200 local idx 4; everything else invalid.
  - Response: entry 0 is {idx 100, data 200}, followed by 90,85,80,75.
- Tie: lane0 {idx 7, data 50} and lane1 {idx 3, data 50} are the only valid entries, last → idx 3 ranks above idx 7; out_count=2; entries 2..4 all-zero.
- Backpressure: out_ready held low 5 cycles after out_valid → in_ready=0, in_valid pulses ignored, out_data unchanged; handshake → out_valid 0 and in_ready 1 on the next cycle.
- Overflow: in_block=0x0800, local idx 1, last → global idx 1, idx_ovf=1; after the handshake, next sort starts with idx_ovf=0.
- Clear and reset mid-sort:
  - sorter_clr in ACCUM → next cycle in_ready=1, running list empty; a new single-beat sort returns only its own entries.
  - sys_rst_n low in DONE → out_valid=0 with no clock edge required.
